// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: CPU-facing command FIFO feeding the draw unit.
// The CPU assembles a 256-bit argument block in a staging register through
// a 32-bit window.
// Writing the opcode address pushes {opcode, staging} into a DEPTH-entry FIFO.
// The head entry is presented to the draw unit and retired on ack.
module draw_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [3:0]         wr_addr,
    input  logic [31:0]        wr_data,
    output logic [7:0]         command,
    output logic [255:0]       data,
    output logic               commit,
    input  logic               ack,
    input  logic               draw_done,
    output logic               full,
    output logic               empty,
    output logic [PTR_W:0]     count,
    output logic               busy,
    output logic               overflow
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    // FIFO storage: opcode in [263:256], arguments in [255:0]; not reset
    logic [263:0]       r_mem [DEPTH];
    logic [255:0]       r_staging;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_in_flight;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_push_req;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_clr;
    logic               w_stage_wr;

    // full/empty come from the pre-edge count so a same-cycle pop cannot rescue a push into a full queue
    assign w_full     = (r_count == CNT_DEPTH);
    assign w_empty    = (r_count == {CNT_W{1'b0}});
    assign w_stage_wr = wr_en && (wr_addr[3] == 1'b0);
    assign w_push_req = wr_en && (wr_addr == 4'd8);
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;
    assign w_clr      = wr_en && (wr_addr == 4'd9);
    assign w_pop      = ack && !w_empty;

    assign command  = r_mem[r_rd_ptr][263:256];
    assign data     = r_mem[r_rd_ptr][255:0];
    assign commit   = !w_empty;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign busy     = !w_empty || r_in_flight;
    assign overflow = r_overflow;

    // Staging register: one 32-bit argument word per CPU write, held across pushes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging <= 256'd0;
        end else if (w_stage_wr) begin
            r_staging[{wr_addr[2:0], 5'b00000} +: 32] <= wr_data;
        end else begin
            r_staging <= r_staging;
        end
    end

    // FIFO storage write on an accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {wr_data[7:0], r_staging};
        end
    end

    // Pointers advance independently and wrap naturally at DEPTH (power of two)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
        end else begin
            r_wr_ptr <= w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
            r_rd_ptr <= w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
        end
    end

    // Occupancy count; simultaneous push and pop leave it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_W{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // In-flight tracking: a pop starts a draw, draw_done ends it; pop wins a tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= 1'b0;
        end else if (w_pop) begin
            r_in_flight <= 1'b1;
        end else if (draw_done) begin
            r_in_flight <= 1'b0;
        end else begin
            r_in_flight <= r_in_flight;
        end
    end

    // Sticky overflow flag; a dropped push wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_clr) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Self-checking bench for draw_cmd_queue: directed steps followed by random
// traffic, all compared against a queue-based reference model.
module tb_draw_cmd_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               wr_en;
    logic [3:0]         wr_addr;
    logic [31:0]        wr_data;
    logic [7:0]         command;
    logic [255:0]       data;
    logic               commit;
    logic               ack;
    logic               draw_done;
    logic               full;
    logic               empty;
    logic [PTR_W:0]     count;
    logic               busy;
    logic               overflow;

    draw_cmd_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .command(command), .data(data), .commit(commit), .ack(ack), .draw_done(draw_done),
        .full(full), .empty(empty), .count(count), .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [263:0] mq[$];
    logic [31:0]  m_stg [8];
    logic         m_inflight;
    logic         m_ov;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) m_stg[i] = 32'd0;
        m_inflight = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":count"},    256'(count),    256'(mq.size()));
        chk({tag, ":empty"},    256'(empty),    256'(mq.size() == 0));
        chk({tag, ":full"},     256'(full),     256'(mq.size() == DEPTH));
        chk({tag, ":commit"},   256'(commit),   256'(mq.size() != 0));
        chk({tag, ":busy"},     256'(busy),     256'((mq.size() != 0) || m_inflight));
        chk({tag, ":overflow"}, 256'(overflow), 256'(m_ov));
        if (mq.size() != 0) begin
            chk({tag, ":command"}, 256'(command), 256'(mq[0][263:256]));
            chk({tag, ":data"},    data,          mq[0][255:0]);
        end
    endtask

    // One clock cycle: inputs applied after the falling edge, model advanced at the
    // rising edge, DUT outputs checked at the next falling edge.
    task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d,
                        input logic ak, input logic dd, input string tag);
        int  pre;
        bit  pop;
        wr_en = we; wr_addr = a; wr_data = d; ack = ak; draw_done = dd;
        @(posedge clk);
        pre = mq.size();
        pop = ak && (pre != 0);
        if (we && a == 4'd9) m_ov = 1'b0;
        if (we && a == 4'd8) begin
            if (pre < DEPTH) mq.push_back({d[7:0], m_stg[7], m_stg[6], m_stg[5], m_stg[4],
                                           m_stg[3], m_stg[2], m_stg[1], m_stg[0]});
            else m_ov = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (we && a < 4'd8) m_stg[a[2:0]] = d;
        if (pop) m_inflight = 1'b1;
        else if (dd) m_inflight = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  ra;
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0; ack = 1'b0; draw_done = 1'b0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        chk("rst:empty", 256'(empty), 256'(1'b1));
        chk("rst:full", 256'(full), 256'(1'b0));
        chk("rst:count", 256'(count), 256'(3'd0));
        chk("rst:commit", 256'(commit), 256'(1'b0));
        chk("rst:busy", 256'(busy), 256'(1'b0));
        chk("rst:overflow", 256'(overflow), 256'(1'b0));

        // Assemble and push one command
        for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 32'h11111111 * (i + 1), 1'b0, 1'b0, "stage");
        step(1'b1, 4'd8, 32'h00000001, 1'b0, 1'b0, "push1");
        chk("t2:command", 256'(command), 256'(8'h01));
        chk("t2:data_lo", 256'(data[31:0]), 256'(32'h11111111));
        chk("t2:data_hi", 256'(data[255:224]), 256'(32'h88888888));
        chk("t2:count", 256'(count), 256'(3'd1));

        // Ack retires the head; draw_done ends the in-flight draw
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, "ack1");
        chk("t3:busy", 256'(busy), 256'(1'b1));
        chk("t3:commit", 256'(commit), 256'(1'b0));
        step(1'b0, 4'd0, 32'd0, 1'b0, 1'b1, "done1");
        chk("t3:busy_off", 256'(busy), 256'(1'b0));

        // Ack while empty is ignored
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, "ack_empty");

        // Five pushes into a four-entry queue, then clear overflow
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'd0, 32'hA0000000 + i, 1'b0, 1'b0, "fill_stage");
            step(1'b1, 4'd8, 32'h10 + i, 1'b0, 1'b0, "fill_push");
        end
        chk("t4:full", 256'(full), 256'(1'b1));
        chk("t4:overflow", 256'(overflow), 256'(1'b1));
        step(1'b1, 4'd9, 32'd0, 1'b0, 1'b0, "clr");
        chk("t4:ov_clr", 256'(overflow), 256'(1'b0));

        // Push while full with same-cycle pop: push still dropped
        step(1'b1, 4'd8, 32'h77, 1'b1, 1'b0, "full_push_pop");
        // Drop plus clear in the same cycle is impossible (one write port); drain to 2
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b1, "drain");
        step(1'b1, 4'd9, 32'd0, 1'b0, 1'b0, "clr2");

        // Simultaneous push and pop at count 2, draining across the pointer wrap
        for (int i = 0; i < 6; i++) step(1'b1, 4'd8, 32'h40 + i, 1'b1, 1'b0, "push_pop");
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b0, "drain_a");
        step(1'b0, 4'd0, 32'd0, 1'b1, 1'b1, "drain_b");
        idle("idle");

        // Asynchronous reset mid-operation with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 4'd8, 32'h60 + i, 1'b0, 1'b0, "pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6:commit", 256'(commit), 256'(1'b0));
        chk("t6:empty", 256'(empty), 256'(1'b1));
        chk("t6:count", 256'(count), 256'(3'd0));
        chk("t6:busy", 256'(busy), 256'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            w  = $urandom;
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ra = 4'd8;
            step(1'($urandom_range(0, 1)), ra, w,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
